demux2_reg: RTL

- Registered 1-to-2 stream demultiplexer: the steering counterpart of the 2:1 select mux used on datapath buses.
- Accepts one word per cycle on a valid/ready input.
- Routes each word by a per-word select bit into one of two single-entry output registers, each with its own valid/ready handshake.
- Sits between a producing pipeline stage and two independent consumers; provides one-cycle latency and full backpressure.

---
 rtl/demux2_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/demux2_reg.sv
// Registered 1-to-2 stream demultiplexer with a single-entry output register per channel.
// Define DEMUX_CNT_EN to add per-channel completed-handshake counters (cnt0/cnt1).
module demux2_reg #(
    parameter int unsigned WIDTH = 32
`ifdef DEMUX_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    logic             valid0_q, valid0_d;
    logic             valid1_q, valid1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;

    logic free0, free1;
    logic acc0, acc1;
    logic drain0, drain1;

    // A channel can take a word if it is empty or is being drained on this edge.
    always_comb begin
        free0    = !valid0_q || out0_ready;
        free1    = !valid1_q || out1_ready;
        in_ready = !reset && (in_sel ? free1 : free0);
        acc0     = in_valid && in_ready && !in_sel;
        acc1     = in_valid && in_ready && in_sel;
        drain0   = valid0_q && out0_ready;
        drain1   = valid1_q && out1_ready;
    end

    always_comb begin
        valid0_d = acc0 || (valid0_q && !drain0);
        valid1_d = acc1 || (valid1_q && !drain1);
        data0_d  = acc0 ? in_data : data0_q;
        data1_d  = acc1 ? in_data : data1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
        end
    end

    assign out0_valid = valid0_q;
    assign out0_data  = data0_q;
    assign out1_valid = valid1_q;
    assign out1_data  = data1_q;

`ifdef DEMUX_CNT_EN
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    // Free-running wrap, no saturation.
    always_comb begin
        cnt0_d = cnt0_q + CNT_WIDTH'(drain0);
        cnt1_d = cnt1_q + CNT_WIDTH'(drain1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
